// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and reset contents for the register file
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    // Power-on contents inherited from the original 8x16 register file
    function automatic reg_data_t RESET_VALUES(input int unsigned index);
        case (index)
            0:       RESET_VALUES = 16'h0001;
            1:       RESET_VALUES = 16'h0002;
            2:       RESET_VALUES = 16'h0004;
            6:       RESET_VALUES = 16'h0040;
            7:       RESET_VALUES = 16'h0042;
            default: RESET_VALUES = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// rtl/regfile_busy_table.sv - per-register pending-producer bits with reserve-over-write priority
module regfile_busy_table #(
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                any_busy
);

    // Clear on writeback first, then set on reserve so a new producer wins a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

    // Drain check looks only at the registered bits
    always_comb begin
        any_busy = |busy;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with bypassed read ports and a RAW busy scoreboard
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_regWrite,
    input  logic [ADDR_W-1:0] wrReg_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rdReg_addr1,
    input  logic [ADDR_W-1:0] rdReg_addr2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    input  logic              sig_reserve,
    input  logic [ADDR_W-1:0] rsvReg_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              any_busy
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_en;
    logic                rsv_en;

    // Writes and reservations aimed at a hardwired zero register are dropped here
    always_comb begin
        wr_en  = sig_regWrite && !((ZERO_REG != 0) && (wrReg_addr == '0));
        rsv_en = sig_reserve  && !((ZERO_REG != 0) && (rsvReg_addr == '0));
    end

    // Storage array: reset loads the legacy contents, a reset during a write discards it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(RESET_VALUES(i));
            end
        end else if (wr_en) begin
            regs[wrReg_addr] <= wr_data;
        end
    end

    regfile_busy_table #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (rsv_en),
        .set_addr (rsvReg_addr),
        .clr_en   (wr_en),
        .clr_addr (wrReg_addr),
        .busy     (busy),
        .any_busy (any_busy)
    );

    // Read port 1: zero register, then same-cycle forwarding of the write and its busy clear
    always_comb begin
        data1 = regs[rdReg_addr1];
        busy1 = busy[rdReg_addr1];
        if ((ZERO_REG != 0) && (rdReg_addr1 == '0)) begin
            data1 = '0;
        end
        if ((BYPASS != 0) && wr_en && (wrReg_addr == rdReg_addr1)) begin
            data1 = wr_data;
            busy1 = rsv_en && (rsvReg_addr == rdReg_addr1);
        end
    end

    // Read port 2: identical selection so both ports agree on a shared address
    always_comb begin
        data2 = regs[rdReg_addr2];
        busy2 = busy[rdReg_addr2];
        if ((ZERO_REG != 0) && (rdReg_addr2 == '0)) begin
            data2 = '0;
        end
        if ((BYPASS != 0) && wr_en && (wrReg_addr == rdReg_addr2)) begin
            data2 = wr_data;
            busy2 = rsv_en && (rsvReg_addr == rdReg_addr2);
        end
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Clocked, parametrised successor of the processor's 8x16 register file.
- Provides:
  - one synchronous write port;
  - two combinational read ports with optional write-to-read bypass;
  - optional hardwired-zero register 0;
  - a per-register busy scoreboard, so the decode stage can stall on read-after-write hazards in the pipelined datapath.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 0, 1 = register 0 always reads 0, and writes/reservations to it are ignored.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_regWrite  in  1  write enable (writeback stage).
- wrReg_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rdReg_addr1  in  ADDR_W  read port 1 address.
- rdReg_addr2  in  ADDR_W  read port 2 address.
- data1  out  DATA_W  read port 1 data (combinational).
- data2  out  DATA_W  read port 2 data (combinational).
- sig_reserve  in  1  mark destination register busy (decode issue).
- rsvReg_addr  in  ADDR_W  register to reserve.
- busy1  out  1  read port 1 register has a pending producer.
- busy2  out  1  read port 2 register has a pending producer.
- any_busy  out  1  OR of all busy bits (drain/flush check).

Behaviour:
- Reset (rst_n low, asynchronous):
  - all busy bits clear;
  - registers load RESET_VALUES from the package: r0=0x0001, r1=0x0002, r2=0x0004, r6=0x0040, r7=0x0042, others 0. Entries beyond 8 registers reset to 0.
  - With ZERO_REG=1, r0 reads 0 regardless of its reset value.
- Reset release: first active edge is the first rising clk with rst_n high. A reset asserted mid-write discards that write.
- Write: on rising clk with sig_regWrite=1, reg[wrReg_addr] <= wr_data. Ignored when ZERO_REG=1 and address is 0.
- Read: data1 = reg[rdReg_addr1] and data2 = reg[rdReg_addr2], zero-latency combinational. Outputs are always valid; there is no read enable.
  - BYPASS=1 and sig_regWrite=1 and wrReg_addr==rdReg_addrN (and not the zero-reg case): dataN = wr_data in the same cycle.
  - BYPASS=0: dataN shows the old value until the edge, the new value from the next cycle.
- Scoreboard: busy[NUM_REGS-1:0].
  - Rising clk, sig_reserve=1: busy[rsvReg_addr] <= 1.
  - Rising clk, sig_regWrite=1: busy[wrReg_addr] <= 0.
  - Same cycle, same address, reserve and write both active: reserve wins, busy stays 1 (new producer issued). The data write still occurs.
  - Same cycle, different addresses: both updates apply.
  - Reserving an already-busy register: stays busy; single outstanding producer per register, no count.
  - Writing a non-busy register: legal, busy stays 0.
  - ZERO_REG=1: busy[0] is constantly 0.
- busyN = busy[rdReg_addrN], except with BYPASS=1 and a same-cycle write hit on that address busyN=0, unless reserve also targets it this cycle. any_busy uses the registered bits only.
- Both read ports may address the same register and the write address simultaneously; both get the identical value.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants, reset-value function RESET_VALUES(index), reg_addr_t/reg_data_t typedefs for the default config.
- One natural sub-module, regfile_busy_table: the scoreboard bit vector with set/clear priority and the any_busy reduction.
- The storage array and bypass muxes stay in the top.

Test Plan:
- Reset check: pulse rst_n low mid-cycle, no clock → data1 at addr 7 = 0x0042, data2 at addr 2 = 0x0004, any_busy=0.
- Write then read, BYPASS=0: write 0xBEEF to r3 → data1(r3)=0x0000 in the write cycle, 0xBEEF on the next cycle.
- Bypass, BYPASS=1: write 0x1234 to r5 while rdReg_addr1=rdReg_addr2=5 → both outputs 0x1234 in the same cycle.
- ZERO_REG=1: write 0xFFFF to r0, reserve r0 → data1(r0)=0, busy1=0, any_busy=0.
- Scoreboard collision: reserve r4 in cycle 1 (busy1(r4)=1 in cycle 2); in cycle 3 write r4 with 0x00AA and reserve r4 → busy stays 1, data=0x00AA. Write r4 again in cycle 4 → busy=0.
- Async reset mid-operation: r1 busy and a write of 0x5555 to r1 pending; drop rst_n before the edge → r1=0x0002, busy clear, write discarded.
